forward_skid_reg: RTL and testbench

FORWARD_SKID_REG -- requirements
Module: forward_skid_reg

---
 rtl/forward_skid_reg.sv | 139 +++++++++++++
 tb/tb_forward_skid_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/forward_skid_reg.sv
// Two-entry forward skid buffer for one layer/row bundle: index fields, a cost-layer flag and two lane vectors.
// Latency: 1 cycle from accept to out_valid. Sustains one bundle per cycle while out_ready stays high.
// Backpressure: the skid entry absorbs one bundle, and in_ready is registered so it never depends on out_ready.
//
// Ports: clk, rst_n (async active-low), flush (sync clear of buffered entries);
//        in_valid/in_ready + w_layer_index, w_row_index, is_cost_layer, z, predict_value (upstream);
//        out_valid/out_ready + *_out fields (downstream).
//        stall_count is present only when FWD_SKID_STALL_CNT_EN is defined.
module forward_skid_reg #(
  parameter int size      = 3,
  parameter int data_size = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               w_layer_index,
  input  logic [31:0]               w_row_index,
  input  logic                      is_cost_layer,
  input  logic [size*data_size-1:0] z,
  input  logic [size*data_size-1:0] predict_value,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               w_layer_index_out,
  output logic [31:0]               w_row_index_out,
  output logic                      is_cost_layer_out,
  output logic [size*data_size-1:0] z_out,
  output logic [size*data_size-1:0] predict_value_out
`ifdef FWD_SKID_STALL_CNT_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  localparam int VW = size * data_size;

  typedef struct packed {
    logic [31:0]   layer;
    logic [31:0]   row;
    logic          cost;
    logic [VW-1:0] z;
    logic [VW-1:0] pv;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t  state;
  bundle_t in_bundle;
  bundle_t main_q;
  bundle_t skid_q;
  logic    accept;
  logic    deliver;

  assign in_bundle = '{layer: w_layer_index, row: w_row_index, cost: is_cost_layer,
                       z: z, pv: predict_value};

  // Both handshakes use the registered flags, so nothing combinational reaches in_ready.
  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // in_ready and out_valid are registered copies of (next_state != FULL) and
  // (next_state != EMPTY). They are updated in the same branch that picks the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Flush empties the buffer. The data registers keep their contents.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          // Covers the first edge after reset, where in_ready rises.
          in_ready <= 1'b1;
          if (accept) begin
            main_q    <= in_bundle;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_q <= in_bundle;
          end else if (accept) begin
            skid_q   <= in_bundle;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (deliver) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low in this state, so only a delivery can occur.
          if (deliver) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign w_layer_index_out = main_q.layer;
  assign w_row_index_out   = main_q.row;
  assign is_cost_layer_out = main_q.cost;
  assign z_out             = main_q.z;
  assign predict_value_out = main_q.pv;

`ifdef FWD_SKID_STALL_CNT_EN
  // Counts cycles in which a bundle waits on the downstream. Saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (flush) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_skid_reg.sv
module tb_forward_skid_reg;

  localparam int VW = 48;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   w_layer_index;
  logic [31:0]   w_row_index;
  logic          is_cost_layer;
  logic [VW-1:0] z;
  logic [VW-1:0] predict_value;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   w_layer_index_out;
  logic [31:0]   w_row_index_out;
  logic          is_cost_layer_out;
  logic [VW-1:0] z_out;
  logic [VW-1:0] predict_value_out;
`ifdef FWD_SKID_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  forward_skid_reg #(.size(3), .data_size(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .w_layer_index     (w_layer_index),
    .w_row_index       (w_row_index),
    .is_cost_layer     (is_cost_layer),
    .z                 (z),
    .predict_value     (predict_value),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .w_layer_index_out (w_layer_index_out),
    .w_row_index_out   (w_row_index_out),
    .is_cost_layer_out (is_cost_layer_out),
    .z_out             (z_out),
    .predict_value_out (predict_value_out)
`ifdef FWD_SKID_STALL_CNT_EN
    ,
    .stall_count       (stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bundle whose fields all derive from the layer index and vector.
  task automatic drive(input logic [31:0] layer, input logic [VW-1:0] zz);
    in_valid      = 1'b1;
    w_layer_index = layer;
    w_row_index   = layer + 32'd1000;
    is_cost_layer = layer[0];
    z             = zz;
    predict_value = ~zz;
  endtask

  // Compare every output field against the bundle that drive() would build.
  task automatic chk_out(input string tag, input logic [31:0] layer, input logic [VW-1:0] zz);
    chk({tag, ".vld"},   {63'd0, out_valid}, 64'd1);
    chk({tag, ".layer"}, {32'd0, w_layer_index_out}, {32'd0, layer});
    chk({tag, ".row"},   {32'd0, w_row_index_out}, {32'd0, layer + 32'd1000});
    chk({tag, ".cost"},  {63'd0, is_cost_layer_out}, {63'd0, layer[0]});
    chk({tag, ".z"},     {16'd0, z_out}, {16'd0, zz});
    chk({tag, ".pv"},    {16'd0, predict_value_out}, {16'd0, ~zz});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    w_layer_index = '0; w_row_index = '0; is_cost_layer = 1'b0; z = '0; predict_value = '0;

    // Reset state
    #12;
    chk("rst.in_ready",  {63'd0, in_ready}, 64'd0);
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.z_out",     {16'd0, z_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst.in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst.out_valid", {63'd0, out_valid}, 64'd0);

    // Single bundle, latency 1, then back to EMPTY
    out_ready = 1'b1;
    drive(32'd2, 48'h0003_0002_0001);
    tick();
    in_valid = 1'b0;
    chk_out("single", 32'd2, 48'h0003_0002_0001);
    tick();
    chk("single.empty", {63'd0, out_valid}, 64'd0);

    // Eight back-to-back bundles with out_ready held high
    for (int i = 0; i < 8; i++) begin
      drive(32'd10 + i, 48'h1111_0000_0000 + 48'(i * 3));
      chk($sformatf("stream%0d.in_ready", i), {63'd0, in_ready}, 64'd1);
      tick();
      chk($sformatf("stream%0d.layer", i), {32'd0, w_layer_index_out}, 64'd10 + i);
      chk($sformatf("stream%0d.vld", i), {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    chk_out("stream_last", 32'd17, 48'h1111_0000_0015);
    tick();
    chk("stream.empty", {63'd0, out_valid}, 64'd0);

    // Backpressure: A and B fill both entries, then drain in order
    out_ready = 1'b0;
    drive(32'd100, 48'hAAAA_AAAA_0001);
    tick();
    drive(32'd101, 48'hBBBB_BBBB_0002);
    chk("bp.one.in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.full.in_ready", {63'd0, in_ready}, 64'd0);
    chk_out("bp.full.A", 32'd100, 48'hAAAA_AAAA_0001);
    tick();
    chk_out("bp.stable.A", 32'd100, 48'hAAAA_AAAA_0001);
    chk("bp.stable.in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    tick();
    chk_out("bp.B", 32'd101, 48'hBBBB_BBBB_0002);
    chk("bp.after_A.in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bp.drained", {63'd0, out_valid}, 64'd0);

    // Flush in FULL takes priority over a simultaneous delivery
    out_ready = 1'b0;
    drive(32'd200, 48'hCCCC_0000_0001);
    tick();
    drive(32'd201, 48'hDDDD_0000_0002);
    tick();
    in_valid = 1'b0;
    chk("flush.pre.in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush.in_ready",  {63'd0, in_ready}, 64'd1);
    chk("flush.hold_data", {32'd0, w_layer_index_out}, 64'd200);
    tick();
    chk("flush.no_deliver", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset between edges while FULL
    out_ready = 1'b0;
    drive(32'd300, 48'hEEEE_0000_0001);
    tick();
    drive(32'd301, 48'hFFFF_0000_0002);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst.in_ready",  {63'd0, in_ready}, 64'd0);
    chk("arst.layer",     {32'd0, w_layer_index_out}, 64'd0);
    chk("arst.z",         {16'd0, z_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst.release.in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst.discarded",        {63'd0, out_valid}, 64'd0);

`ifdef FWD_SKID_STALL_CNT_EN
    // Stall counter: 5 cycles, then saturation, then cleared by flush
    out_ready = 1'b0;
    drive(32'd400, 48'h0000_0000_0400);
    tick();
    in_valid = 1'b0;
    chk("stall.start", {48'd0, stall_count}, 64'd0);
    repeat (5) tick();
    chk("stall.five", {48'd0, stall_count}, 64'd5);
    repeat (70000) tick();
    chk("stall.sat", {48'd0, stall_count}, 64'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("stall.flush", {48'd0, stall_count}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
